// File: rtl/sipo_deser_if.sv
// Serial-in / parallel-out bus for sipo_deser: serial input side, flush control,
// valid/ready parallel output side and status.
interface sipo_deser_if #(
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             sin;
  logic             sin_valid;
  logic             clr;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;

  // Driver/consumer side: supplies serial bits and accepts parallel words.
  modport master (
    output sin, sin_valid, clr, pout_ready,
    input  pout, pout_valid, bit_cnt, overrun
  );

  // Deserializer side.
  modport slave (
    input  sin, sin_valid, clr, pout_ready,
    output pout, pout_valid, bit_cnt, overrun
  );
endinterface

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: gathers WIDTH qualified serial bits, hands
// each completed word to a valid/ready holding register and flags overruns.
module sipo_deser #(
  parameter int WIDTH     = 4,     // 2 .. 32
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  sipo_deser_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             complete;
  logic             accept;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    shreg_next = shreg;
    if (MSB_FIRST) shreg_next = {shreg[WIDTH-2:0], bus.sin};
    else           shreg_next = {bus.sin, shreg[WIDTH-1:1]};
  end

  // clr discards the bit sampled on its edge, so it also suppresses completion.
  assign complete = bus.sin_valid && !bus.clr && (bus.bit_cnt == CW'(WIDTH - 1));
  assign accept   = bus.pout_valid && bus.pout_ready;

  // NOTE: all state here is registered with non-blocking assignments so every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg          <= '0;
      bus.bit_cnt    <= '0;
      bus.pout       <= '0;
      bus.pout_valid <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      if (bus.clr) begin
        bus.bit_cnt <= '0;
        bus.overrun <= 1'b0;
      end else if (bus.sin_valid) begin
        shreg       <= shreg_next;
        bus.bit_cnt <= complete ? '0 : bus.bit_cnt + 1'b1;
      end

      if (complete) begin
        // Free slot (empty or being accepted this edge): load; otherwise drop.
        if (!bus.pout_valid || bus.pout_ready) begin
          bus.pout       <= shreg_next;
          bus.pout_valid <= 1'b1;
        end else begin
          bus.overrun    <= 1'b1;
        end
      end else if (accept) begin
        bus.pout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: LSB-first and MSB-first instances share stimulus
// and are checked against a queue-based reference model.
module tb_sipo_deser;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sin = 1'b0, sin_valid = 1'b0, pout_ready = 1'b0, clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(W)) if0 ();
  sipo_deser_if #(.WIDTH(W)) if1 ();

  assign if0.sin = sin;  assign if0.sin_valid = sin_valid;
  assign if0.clr = clr;  assign if0.pout_ready = pout_ready;
  assign if1.sin = sin;  assign if1.sin_valid = sin_valid;
  assign if1.clr = clr;  assign if1.pout_ready = pout_ready;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: received bits as a list, one pending-word slot per instance
  // (index 0 = LSB-first, 1 = MSB-first) and a queue of words awaiting acceptance.
  bit         bits_q [2][$];
  logic [W-1:0] exp_q [2][$];
  logic [W-1:0] m_pout [2] = '{default: '0};
  bit         m_valid [2] = '{default: 1'b0};
  bit         m_ovr   [2] = '{default: 1'b0};

  function automatic logic [W-1:0] assemble(input int d);
    logic [W-1:0] w = '0;
    for (int i = 0; i < W; i++) begin
      if (d == 0) w[i] = bits_q[d][i];
      else        w[W-1-i] = bits_q[d][i];
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        bits_q[d].delete();
        exp_q[d].delete();
        m_pout[d]  = '0;
        m_valid[d] = 1'b0;
        m_ovr[d]   = 1'b0;
      end else begin
        if (m_valid[d] && pout_ready) m_valid[d] = 1'b0;
        if (clr) begin
          bits_q[d].delete();
          m_ovr[d] = 1'b0;
        end else if (sin_valid) begin
          bits_q[d].push_back(sin);
          if (bits_q[d].size() == W) begin
            logic [W-1:0] w;
            w = assemble(d);
            bits_q[d].delete();
            if (m_valid[d]) m_ovr[d] = 1'b1;
            else begin
              m_valid[d] = 1'b1;
              m_pout[d]  = w;
              exp_q[d].push_back(w);
            end
          end
        end
      end
    end
  end

  // Monitor: runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [W-1:0] a_pout [2];
      logic         a_val  [2];
      logic [31:0]  a_cnt  [2];
      logic         a_ovr  [2];
      a_pout[0] = if0.pout; a_val[0] = if0.pout_valid; a_cnt[0] = 32'(if0.bit_cnt); a_ovr[0] = if0.overrun;
      a_pout[1] = if1.pout; a_val[1] = if1.pout_valid; a_cnt[1] = 32'(if1.bit_cnt); a_ovr[1] = if1.overrun;
      for (int d = 0; d < 2; d++) begin
        check($sformatf("bit_cnt[%0d]", d), a_cnt[d], 32'(bits_q[d].size()));
        check($sformatf("overrun[%0d]", d), 32'(a_ovr[d]), 32'(m_ovr[d]));
        check($sformatf("pout_valid[%0d]", d), 32'(a_val[d]), 32'(m_valid[d]));
        if (a_val[d] && pout_ready) begin
          if (exp_q[d].size() == 0) begin
            check($sformatf("unexpected_word[%0d]", d), 32'(a_pout[d]), 32'hFFFF_FFFF);
          end else begin
            logic [W-1:0] e;
            e = exp_q[d].pop_front();
            check($sformatf("word[%0d]", d), 32'(a_pout[d]), 32'(e));
          end
        end
      end
    end
  end

  // Sets the inputs sampled by the next rising edge; outputs then reflect the
  // previous edge's inputs.
  task automatic cyc(input logic s, input logic v, input logic r, input logic c);
    @(posedge clk);
    #1;
    sin = s; sin_valid = v; pout_ready = r; clr = c;
  endtask

  task automatic send_word(input logic [W-1:0] bits_lsb_first, input logic r);
    for (int i = 0; i < W; i++) cyc(bits_lsb_first[i], 1'b1, r, 1'b0);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #3;
    check("reset_pout", 32'(if0.pout), 32'h0);
    check("reset_valid", 32'(if0.pout_valid), 32'h0);
    check("reset_cnt", 32'(if0.bit_cnt), 32'h0);
    rst_n = 1'b1;

    // LSB-first basic word 1,1,0,1
    send_word(4'b1011, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("lsb_pout", 32'(if0.pout), 32'hB);
    check("lsb_valid", 32'(if0.pout_valid), 32'h1);
    check("lsb_cnt_wrap", 32'(if0.bit_cnt), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("lsb_valid_drop", 32'(if0.pout_valid), 32'h0);

    // MSB-first 1,0,1,1 with 3-cycle gaps
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("msb_gap_hold", 32'(if1.bit_cnt), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("msb_pout", 32'(if1.pout), 32'hB);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Backpressure and overrun
    send_word(4'b0110, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_valid", 32'(if0.pout_valid), 32'h1);
    check("bp_pout", 32'(if0.pout), 32'h6);
    send_word(4'b1001, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_set", 32'(if0.overrun), 32'h1);
    check("ovr_pout_kept", 32'(if0.pout), 32'h6);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_accept_valid", 32'(if0.pout_valid), 32'h0);
    check("ovr_sticky", 32'(if0.overrun), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_clr", 32'(if0.overrun), 32'h0);

    // Back-to-back: accept A on the completion edge of 5
    send_word(4'hA, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("b2b_old", 32'(if0.pout), 32'hA);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("b2b_new", 32'(if0.pout), 32'h5);
    check("b2b_valid", 32'(if0.pout_valid), 32'h1);
    check("b2b_no_ovr", 32'(if0.overrun), 32'h0);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Flush mid-word, clr beats sin_valid
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("flush_cnt", 32'(if0.bit_cnt), 32'h0);
    send_word(4'b0011, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("flush_word", 32'(if0.pout), 32'h3);
    check("flush_valid", 32'(if0.pout_valid), 32'h1);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Async reset mid-word with a pending word
    send_word(4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    sin = 1'b0; sin_valid = 1'b0; pout_ready = 1'b0; clr = 1'b0;
    check("pre_rst_cnt", 32'(if0.bit_cnt), 32'h3);
    check("pre_rst_valid", 32'(if0.pout_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_pout", 32'(if0.pout), 32'h0);
    check("arst_valid", 32'(if0.pout_valid), 32'h0);
    check("arst_cnt", 32'(if0.bit_cnt), 32'h0);
    check("arst_ovr", 32'(if0.overrun), 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    send_word(4'b1110, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("post_rst_word", 32'(if0.pout), 32'hE);
    repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 39) == 0);
    end
    repeat (4) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
